// File: rtl/dram_port_bist.sv
// dram_port_bist: native DRAM port BIST engine.
// Writes an address-derived pattern, reads it back and counts mismatches.
module dram_port_bist #(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 25,
  parameter int LEN_W   = 16,
  parameter int MAX_OUT = 8
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [1:0]          mode,
  input  logic                pattern_sel,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [15:0]         error_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_we,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic                wdata_valid,
  input  logic                wdata_ready,
  output logic [DATA_W/8-1:0] wdata_we,
  output logic [DATA_W-1:0]   wdata_data,
  input  logic                rdata_valid,
  output logic                rdata_ready,
  input  logic [DATA_W-1:0]   rdata_data
);
  localparam int LANES = DATA_W / 32;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic              pat_q, pat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        out_q, out_d;
  logic [15:0]       err_q, err_d;
  logic              cmd_v_q, cmd_v_d;
  logic              cmd_we_q, cmd_we_d;
  logic              wd_v_q, wd_v_d;
  logic              abort_q, abort_d;
  logic              busy_q, done_q, rdy_q;
  logic              cmd_acc, wd_acc, rsp_acc, rd_acc;

  // Lane i of the word at address a is a+i; inverted when inv is set
  function automatic logic [DATA_W-1:0] pattern(
    input logic [ADDR_W-1:0] a,
    input logic              inv
  );
    logic [DATA_W-1:0] p;
    logic [31:0]       a32;
    a32 = 32'(a);
    p   = '0;
    for (int i = 0; i < LANES; i++) p[i*32 +: 32] = a32 + 32'(i);
    return inv ? ~p : p;
  endfunction

  // Next-state, command sequencing and read-data checking
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    base_d     = base_q;
    addr_d     = addr_q;
    rsp_addr_d = rsp_addr_q;
    first_d    = first_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    cmd_v_d    = cmd_v_q;
    cmd_we_d   = cmd_we_q;
    wd_v_d     = wd_v_q;
    abort_d    = abort_q;
    cmd_acc    = cmd_v_q & cmd_ready;
    wd_acc     = wd_v_q & wdata_ready;
    rsp_acc    = rdata_valid & rdy_q;
    rd_acc     = cmd_acc & ~cmd_we_q;

    if (rsp_acc) begin
      rsp_addr_d = rsp_addr_q + ADDR_W'(1);
      if (rdata_data != pattern(rsp_addr_q, pat_q)) begin
        if (err_q == 16'd0) first_d = rsp_addr_q;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
    end

    unique case ({rd_acc, rsp_acc && out_q != 8'd0})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = out_q - 8'd1;
      default: out_d = out_q;
    endcase

    if (state_q inside {WRITE, READ, DRAIN}) abort_d = abort_q | abort;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d     = mode;
          pat_d      = pattern_sel;
          base_d     = base_addr;
          len_d      = length;
          addr_d     = base_addr;
          rsp_addr_d = base_addr;
          cnt_d      = '0;
          out_d      = '0;
          err_d      = '0;
          first_d    = '0;
          abort_d    = 1'b0;
          if (length == '0) begin
            state_d = DONE;
          end else if (mode == 2'd1) begin
            state_d  = READ;
            cmd_v_d  = 1'b1;
            cmd_we_d = 1'b0;
          end else begin
            state_d  = WRITE;
            cmd_v_d  = 1'b1;
            wd_v_d   = 1'b1;
            cmd_we_d = 1'b1;
          end
        end
      end
      WRITE: begin
        cmd_v_d = cmd_v_q & ~cmd_acc;
        wd_v_d  = wd_v_q & ~wd_acc;
        if (!cmd_v_d && !wd_v_d) begin
          cnt_d  = cnt_q + LEN_W'(1);
          addr_d = addr_q + ADDR_W'(1);
          if (cnt_d != len_q && !abort_d) begin
            cmd_v_d = 1'b1;
            wd_v_d  = 1'b1;
          end else if (abort_d || mode_q == 2'd0) begin
            state_d = DONE;
          end else begin
            state_d  = READ;
            cnt_d    = '0;
            addr_d   = base_q;
            cmd_v_d  = 1'b1;
            cmd_we_d = 1'b0;
          end
        end
      end
      READ: begin
        if (cmd_acc) begin
          cnt_d  = cnt_q + LEN_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
        if (cmd_v_q && !cmd_acc) begin
          cmd_v_d = 1'b1;
        end else if (cnt_d != len_q && !abort_d &&
                     out_d < 8'(MAX_OUT)) begin
          cmd_v_d = 1'b1;
        end else begin
          cmd_v_d = 1'b0;
          if (cnt_d == len_q || abort_d) state_d = DRAIN;
        end
      end
      DRAIN: if (out_q == 8'd0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers and registered status outputs
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= IDLE;
      mode_q     <= 2'd0;
      pat_q      <= 1'b0;
      base_q     <= '0;
      addr_q     <= '0;
      rsp_addr_q <= '0;
      first_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      out_q      <= 8'd0;
      err_q      <= 16'd0;
      cmd_v_q    <= 1'b0;
      cmd_we_q   <= 1'b0;
      wd_v_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      rsp_addr_q <= rsp_addr_d;
      first_q    <= first_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      err_q      <= err_d;
      cmd_v_q    <= cmd_v_d;
      cmd_we_q   <= cmd_we_d;
      wd_v_q     <= wd_v_d;
      abort_q    <= abort_d;
      busy_q     <= state_d inside {WRITE, READ, DRAIN};
      done_q     <= state_d == DONE;
      rdy_q      <= state_d inside {READ, DRAIN};
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = abort_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;
  assign cmd_valid      = cmd_v_q;
  assign cmd_we         = cmd_we_q;
  assign cmd_addr       = addr_q;
  assign wdata_valid    = wd_v_q;
  assign wdata_we       = '1;
  assign wdata_data     = pattern(addr_q, pat_q);
  assign rdata_ready    = rdy_q;

endmodule

// File: tb/tb_dram_port_bist.sv
// tb_dram_port_bist: directed bench for dram_port_bist.
// Two instances (MAX_OUT 4 and 2) share stimulus, each with its own memory model.
module tb_dram_port_bist;
  logic             user_clk = 1'b0;
  logic             user_rst_n;
  logic             start, abort;
  logic [1:0]       mode;
  logic             pattern_sel;
  logic [7:0]       base_addr, length;
  logic [1:0]       busy, done, aborted;
  logic [1:0]       cmd_valid, cmd_ready, cmd_we;
  logic [1:0]       wdata_valid, wdata_ready;
  logic [1:0]       rdata_valid, rdata_ready;
  logic [1:0][15:0] error_count;
  logic [1:0][7:0]  first_err_addr, cmd_addr, wdata_we;
  logic [1:0][63:0] wdata_data, rdata_data;

  int errors = 0;
  int checks = 0;

  int lat;
  logic stall, flip_en, clr_max;
  logic [7:0] flip_a;

  int cyc = 0;
  int nca[2] = '{default: 0};
  int nda[2] = '{default: 0};
  int wk[2] = '{default: 0};
  int tl[2] = '{default: 0};
  int hd[2] = '{default: 0};
  int done_cnt[2] = '{default: 0};
  int maxo[2] = '{default: 0};
  logic [7:0]  addr_log [2][256];
  logic [63:0] data_log [2][256];
  logic [7:0]  rq_addr [2][256];
  int          rq_due [2][256];
  logic [63:0] mem [2][256];
  int          wcnt [2][256];

  int s_wr[2], s_wd[2], s_rd[2], s_rsp[2], s_done[2];
  logic [7:0] exp_c [4];

  always #5 user_clk = ~user_clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dram_port_bist #(
      .DATA_W(64), .ADDR_W(8), .LEN_W(8),
      .MAX_OUT(g == 0 ? 4 : 2)
    ) u_dut (
      .user_clk(user_clk), .user_rst_n(user_rst_n),
      .start(start), .abort(abort), .mode(mode),
      .pattern_sel(pattern_sel), .base_addr(base_addr),
      .length(length), .busy(busy[g]), .done(done[g]),
      .aborted(aborted[g]), .error_count(error_count[g]),
      .first_err_addr(first_err_addr[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
      .cmd_we(cmd_we[g]), .cmd_addr(cmd_addr[g]),
      .wdata_valid(wdata_valid[g]), .wdata_ready(wdata_ready[g]),
      .wdata_we(wdata_we[g]), .wdata_data(wdata_data[g]),
      .rdata_valid(rdata_valid[g]), .rdata_ready(rdata_ready[g]),
      .rdata_data(rdata_data[g])
    );
  end

  function automatic logic [63:0] pat(input logic [7:0] a, input logic inv);
    logic [31:0] lo, hi;
    lo = {24'd0, a};
    hi = lo + 32'd1;
    return inv ? ~{hi, lo} : {hi, lo};
  endfunction

  // Memory model: log accepted commands and data, pair them into writes
  always @(posedge user_clk) begin
    if (!user_rst_n) begin
      cyc <= 0;
      for (int g = 0; g < 2; g++) begin
        nca[g] <= 0; nda[g] <= 0; wk[g] <= 0;
        tl[g] <= 0; hd[g] <= 0; done_cnt[g] <= 0;
        for (int a = 0; a < 256; a++) begin
          mem[g][a]  <= 64'd0;
          wcnt[g][a] <= 0;
        end
      end
    end else begin
      cyc <= cyc + 1;
      for (int g = 0; g < 2; g++) begin
        if (done[g]) done_cnt[g] <= done_cnt[g] + 1;
        if (cmd_valid[g] && cmd_ready[g] && cmd_we[g]) begin
          addr_log[g][nca[g]] <= cmd_addr[g];
          nca[g] <= nca[g] + 1;
        end
        if (wdata_valid[g] && wdata_ready[g]) begin
          data_log[g][nda[g]] <= wdata_data[g];
          nda[g] <= nda[g] + 1;
        end
        if (cmd_valid[g] && cmd_ready[g] && !cmd_we[g]) begin
          rq_addr[g][tl[g]] <= cmd_addr[g];
          rq_due[g][tl[g]]  <= cyc + lat;
          tl[g] <= tl[g] + 1;
        end
        if (rdata_valid[g] && rdata_ready[g]) hd[g] <= hd[g] + 1;
        if (wk[g] < nca[g] && wk[g] < nda[g]) begin
          mem[g][addr_log[g][wk[g]]]  <= data_log[g][wk[g]];
          wcnt[g][addr_log[g][wk[g]]] <= wcnt[g][addr_log[g][wk[g]]] + 1;
          wk[g] <= wk[g] + 1;
        end
      end
    end
  end

  // Drive ready/response inputs away from the active edge
  always @(negedge user_clk) begin
    for (int g = 0; g < 2; g++) begin
      cmd_ready[g]   <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wdata_ready[g] <= stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (clr_max) maxo[g] <= 0;
      else if (tl[g] - hd[g] > maxo[g]) maxo[g] <= tl[g] - hd[g];
      if (hd[g] < tl[g] && rq_due[g][hd[g]] <= cyc) begin
        rdata_valid[g] <= 1'b1;
        rdata_data[g]  <= mem[g][rq_addr[g][hd[g]]] ^
          ((flip_en && rq_addr[g][hd[g]] == flip_a) ? 64'd1 : 64'd0);
      end else begin
        rdata_valid[g] <= 1'b0;
        rdata_data[g]  <= 64'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [1:0] m, input logic p,
                      input logic [7:0] b, input logic [7:0] l);
    @(negedge user_clk);
    for (int g = 0; g < 2; g++) begin
      s_wr[g] = nca[g]; s_wd[g] = nda[g]; s_rd[g] = tl[g];
      s_rsp[g] = hd[g]; s_done[g] = done_cnt[g];
    end
    mode = m; pattern_sel = p; base_addr = b; length = l;
    start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!(done_cnt[0] > s_done[0] && done_cnt[1] > s_done[1]) &&
           t < 4000) begin
      @(negedge user_clk);
      t++;
    end
    chk("done_in_time", 64'(t < 4000), 64'd1);
    repeat (4) @(negedge user_clk);
  endtask

  initial begin
    lat = 2; stall = 1'b0; flip_en = 1'b0; flip_a = 8'd0; clr_max = 1'b1;
    start = 1'b0; abort = 1'b0; mode = 2'd0; pattern_sel = 1'b0;
    base_addr = 8'd0; length = 8'd0;
    exp_c = '{8'd254, 8'd255, 8'd0, 8'd1};
    user_rst_n = 1'b0;
    repeat (3) @(negedge user_clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_wdata_valid", 64'(wdata_valid), 64'd0);
    chk("rst_rdata_ready", 64'(rdata_ready), 64'd0);
    chk("rst_err", 64'(error_count[0]), 64'd0);
    chk("rst_first", 64'(first_err_addr[0]), 64'd0);
    user_rst_n = 1'b1;
    repeat (2) @(negedge user_clk);
    clr_max = 1'b0;

    // write-then-check, base 0, 8 words
    kick(2'd2, 1'b0, 8'd0, 8'd8);
    chk("a_busy", 64'(busy[0]), 64'd1);
    chk("a_cmd_we", 64'(cmd_we[0]), 64'd1);
    chk("a_wdata_we", 64'(wdata_we[0]), 64'hFF);
    wait_done();
    chk("a_done_pulse", 64'(done_cnt[0] - s_done[0]), 64'd1);
    chk("a_writes", 64'(nca[0] - s_wr[0]), 64'd8);
    chk("a_wdata", 64'(nda[0] - s_wd[0]), 64'd8);
    chk("a_reads", 64'(tl[0] - s_rd[0]), 64'd8);
    chk("a_resps", 64'(hd[0] - s_rsp[0]), 64'd8);
    chk("a_data3", data_log[0][s_wd[0] + 3], pat(8'd3, 1'b0));
    chk("a_mem7", mem[0][7], pat(8'd7, 1'b0));
    chk("a_err", 64'(error_count[0]), 64'd0);
    chk("a_aborted", 64'(aborted[0]), 64'd0);
    chk("a_busy_end", 64'(busy[0]), 64'd0);

    // read-check with one corrupted word at address 2
    flip_en = 1'b1; flip_a = 8'd2;
    kick(2'd1, 1'b0, 8'd0, 8'd4);
    wait_done();
    flip_en = 1'b0;
    chk("b_err", 64'(error_count[0]), 64'd1);
    chk("b_first", 64'(first_err_addr[0]), 64'd2);
    chk("b_err_i1", 64'(error_count[1]), 64'd1);
    chk("b_no_writes", 64'(nca[0] - s_wr[0]), 64'd0);
    chk("b_resps", 64'(hd[0] - s_rsp[0]), 64'd4);

    // address wrap at the top of the space
    kick(2'd3, 1'b0, 8'd254, 8'd4);
    wait_done();
    for (int k = 0; k < 4; k++)
      chk("c_wr_addr", 64'(addr_log[0][s_wr[0] + k]), 64'(exp_c[k]));
    chk("c_rd_addr3", 64'(rq_addr[0][s_rd[0] + 3]), 64'd1);
    chk("c_err_cleared", 64'(error_count[0]), 64'd0);
    chk("c_first_cleared", 64'(first_err_addr[0]), 64'd0);

    // long read latency limits outstanding; start mid-run is ignored
    lat = 20;
    clr_max = 1'b1;
    repeat (2) @(negedge user_clk);
    clr_max = 1'b0;
    kick(2'd2, 1'b0, 8'd32, 8'd16);
    repeat (5) @(negedge user_clk);
    mode = 2'd0; length = 8'd0; start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    wait_done();
    chk("d_max_out_i1", 64'(maxo[1]), 64'd2);
    chk("d_max_out_i0", 64'(maxo[0]), 64'd4);
    chk("d_resps_i1", 64'(hd[1] - s_rsp[1]), 64'd16);
    chk("d_resps_i0", 64'(hd[0] - s_rsp[0]), 64'd16);
    chk("d_writes", 64'(nca[0] - s_wr[0]), 64'd16);
    chk("d_err_i1", 64'(error_count[1]), 64'd0);
    chk("d_err_i0", 64'(error_count[0]), 64'd0);
    chk("d_one_done", 64'(done_cnt[0] - s_done[0]), 64'd1);

    // write-only with random ready stalls, inverted pattern
    lat = 2; stall = 1'b1;
    kick(2'd0, 1'b1, 8'd16, 8'd12);
    wait_done();
    stall = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk("e_wcnt", 64'(wcnt[0][16 + k]), 64'd1);
      chk("e_mem", mem[0][16 + k], pat(8'(16 + k), 1'b1));
    end
    chk("e_wcnt_i1", 64'(wcnt[1][27]), 64'd1);
    chk("e_no_reads", 64'(tl[0] - s_rd[0]), 64'd0);
    chk("e_writes", 64'(nca[0] - s_wr[0]), 64'd12);

    // abort while the third read command is being accepted
    lat = 20;
    kick(2'd1, 1'b0, 8'd0, 8'd16);
    begin
      int t;
      t = 0;
      while (tl[0] - s_rd[0] < 2 && t < 100) begin
        @(negedge user_clk);
        t++;
      end
      chk("f_reach_two", 64'(t < 100), 64'd1);
    end
    abort = 1'b1;
    @(negedge user_clk);
    abort = 1'b0;
    wait_done();
    chk("f_reads", 64'(tl[0] - s_rd[0]), 64'd3);
    chk("f_resps", 64'(hd[0] - s_rsp[0]), 64'd3);
    chk("f_aborted", 64'(aborted[0]), 64'd1);
    chk("f_done", 64'(done_cnt[0] - s_done[0]), 64'd1);
    chk("f_busy", 64'(busy[0]), 64'd0);
    chk("f_err", 64'(error_count[0]), 64'd0);
    chk("f_reads_i1", 64'(tl[1] - s_rd[1]), 64'd2);
    chk("f_aborted_i1", 64'(aborted[1]), 64'd1);

    // zero length: straight to done, clears aborted
    kick(2'd2, 1'b0, 8'd0, 8'd0);
    wait_done();
    chk("g_done", 64'(done_cnt[0] - s_done[0]), 64'd1);
    chk("g_no_cmd", 64'(nca[0] - s_wr[0] + tl[0] - s_rd[0]), 64'd0);
    chk("g_aborted_clr", 64'(aborted[0]), 64'd0);

    // reset in the middle of a run
    kick(2'd1, 1'b0, 8'd0, 8'd16);
    repeat (4) @(negedge user_clk);
    user_rst_n = 1'b0;
    #1;
    chk("h_busy", 64'(busy), 64'd0);
    chk("h_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("h_rdata_ready", 64'(rdata_ready), 64'd0);
    repeat (3) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (40) @(negedge user_clk);
    chk("h_no_done", 64'(done_cnt[0]), 64'd0);
    chk("h_idle_cmd", 64'(tl[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
